mul_accum: RTL



---
 rtl/alu_pkg.sv | 21 ++
 rtl/mul_accum_if.sv | 32 +++
 rtl/mul_accum_sm_to_tc.sv | 20 ++
 rtl/mul_accum.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multiply-accumulate result path: FSM state
// encoding, product format of the upstream sign-magnitude multiplier and
// default accumulator/counter widths.
package alu_pkg;

  // Product stream format coming from the 3-bit signed multiplier
  localparam int PROD_W    = 5;
  localparam int PROD_SIGN = 4;

  // Default widths of the accumulator/result and the beat counter
  localparam int ACC_W_DEF = 8;
  localparam int CNT_W_DEF = 4;

  // Burst FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage : alu_pkg

// File: rtl/mul_accum_if.sv
// Handshake bundle between the product source, the accumulator and the
// ALU result path. The master modport is the side that drives products in
// and consumes results; the slave modport is the accumulator itself.
interface mul_accum_if
  import alu_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_prod, in_last, clear, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, clear, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface : mul_accum_if

// File: rtl/mul_accum_sm_to_tc.sv
// Purely combinational sign-magnitude to two's-complement converter.
// A negative zero (sign set, magnitude zero) maps to plain zero.
module sm_to_tc
  import alu_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_val
);

  logic [ACC_W-1:0] w_mag;

  // Zero-extend the magnitude, then negate it when the sign bit is set
  always_comb begin
    w_mag = {{(ACC_W-PROD_W+1){1'b0}}, i_prod[PROD_W-2:0]};
    o_val = i_prod[PROD_SIGN] ? (-w_mag) : w_mag;
  end

endmodule : sm_to_tc

// File: rtl/mul_accum.sv
// Multiply-accumulate burst collector. Accepts sign-magnitude products,
// sums them in two's complement over a burst closed by in_last, and holds
// the sum, beat count and sticky overflow flag until the result path
// takes them.
// Optional build macro: MUL_ACCUM_SAT_EN -- when defined the accumulator
// saturates at its signed limits instead of wrapping; ovf is set either way.
module mul_accum
  import alu_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  mul_accum_if.slave  bus
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_nextState;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_nextAcc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_nextCount;
  logic             r_ovf;
  logic             w_nextOvf;
  logic             w_loadOut;

  logic [ACC_W-1:0] r_outSum;
  logic [CNT_W-1:0] r_outCount;
  logic             r_outOvf;

  logic [ACC_W-1:0] w_val;
  logic             w_inReady;
  logic             w_accept;
  logic [ACC_W:0]   w_sumExt;
  logic             w_addOvf;
  logic [ACC_W-1:0] w_addResult;
  logic [CNT_W-1:0] w_countInc;

  sm_to_tc #(
    .ACC_W (ACC_W)
  ) u_sm_to_tc (
    .i_prod (bus.in_prod),
    .o_val  (w_val)
  );

  assign w_inReady     = (r_state != ST_HOLD);
  assign w_accept      = bus.in_valid & w_inReady;
  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = (r_state == ST_HOLD);
  assign bus.out_sum   = r_outSum;
  assign bus.out_count = r_outCount;
  assign bus.out_ovf   = r_outOvf;

  // Sign-extended add; overflow shows as disagreement of the top two bits,
  // and the extra top bit tells which limit a clamp should go to
  always_comb begin
    w_sumExt    = {r_acc[ACC_W-1], r_acc} + {w_val[ACC_W-1], w_val};
    w_addOvf    = w_sumExt[ACC_W] ^ w_sumExt[ACC_W-1];
`ifdef MUL_ACCUM_SAT_EN
    if (w_addOvf) begin
      w_addResult = w_sumExt[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      w_addResult = w_sumExt[ACC_W-1:0];
    end
`else
    w_addResult = w_sumExt[ACC_W-1:0];
`endif
    w_countInc  = (r_count == CNT_MAX) ? r_count : (r_count + CNT_ONE);
  end

  // Next-state and datapath update; clear overrides accept and handshake
  always_comb begin
    w_nextState = r_state;
    w_nextAcc   = r_acc;
    w_nextCount = r_count;
    w_nextOvf   = r_ovf;
    w_loadOut   = 1'b0;
    if (bus.clear) begin
      w_nextState = ST_IDLE;
      w_nextAcc   = '0;
      w_nextCount = '0;
      w_nextOvf   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_nextAcc   = w_val;
            w_nextCount = CNT_ONE;
            w_nextOvf   = 1'b0;
            w_nextState = bus.in_last ? ST_HOLD : ST_ACCUM;
            w_loadOut   = bus.in_last;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            w_nextAcc   = w_addResult;
            w_nextCount = w_countInc;
            w_nextOvf   = r_ovf | w_addOvf;
            if (bus.in_last) begin
              w_nextState = ST_HOLD;
              w_loadOut   = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            w_nextState = ST_IDLE;
          end
        end
        default: begin
          w_nextState = ST_IDLE;
        end
      endcase
    end
  end

  // State and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_acc   <= w_nextAcc;
      r_count <= w_nextCount;
      r_ovf   <= w_nextOvf;
    end
  end

  // Result registers capture only on entry into HOLD and otherwise keep
  // their last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outSum   <= '0;
      r_outCount <= '0;
      r_outOvf   <= 1'b0;
    end else if (w_loadOut) begin
      r_outSum   <= w_nextAcc;
      r_outCount <= w_nextCount;
      r_outOvf   <= w_nextOvf;
    end
  end

endmodule : mul_accum
